ins_cache: RTL

- Instruction-side responder to the fetch unit's request interface. Accepts a one-cycle `ins_call` pulse with `addr_in` and returns one 32-bit instruction with a one-cycle `cache_en` pulse.
- Direct-mapped, one 32-bit word per line.
- Hits return from the array. Misses run a 4-byte little-endian fill over the byte-wide memory port (via the memory arbiter), write the line, then respond.

---
 rtl/ins_cache.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ins_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line, refilled little-endian over a byte port.
// Optional hit/miss statistics counters are built when ICACHE_STAT_EN is defined.
module ins_cache #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ins_call,
  input  logic [ADR_W-1:0] addr_in,
  output logic             cache_en,
  output logic [DAT_W-1:0] cache_ins,
  output logic             busy,
  output logic             mem_req,
  output logic [ADR_W-1:0] mem_addr,
  input  logic             mem_valid,
  input  logic [7:0]       mem_din
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int TAG_W = ADR_W - IDX_W - 2;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               cache_en_q, cache_en_d;
  logic [DAT_W-1:0]   cache_ins_q, cache_ins_d;
  logic               busy_q, busy_d;
  logic               mem_req_q, mem_req_d;
  logic [ADR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DAT_W-9:0]   fill_q, fill_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [LINES-1:0]   valid_q, valid_d;
`ifdef ICACHE_STAT_EN
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
`endif

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DAT_W-1:0]   data_mem [LINES];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               wr_en;
  logic [DAT_W-1:0]   wr_data;
  logic               unused_addr_bits;

  assign req_idx          = addr_in[IDX_W+1:2];
  assign req_tag          = addr_in[ADR_W-1:IDX_W+2];
  assign hit              = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_bits = ^addr_in[1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cache_en_d  = cache_en_q;
    cache_ins_d = cache_ins_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_data     = {mem_din, fill_q};
`ifdef ICACHE_STAT_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    if (en) begin
      cache_en_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (ins_call && !clr) begin
            idx_d = req_idx;
            tag_d = req_tag;
            if (hit) begin
              cache_en_d  = 1'b1;
              cache_ins_d = data_mem[req_idx];
`ifdef ICACHE_STAT_EN
              if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
            end else begin
              busy_d     = 1'b1;
              mem_req_d  = 1'b1;
              mem_addr_d = {addr_in[ADR_W-1:2], 2'b00};
              cnt_d      = 2'd0;
              state_d    = FILL;
`ifdef ICACHE_STAT_EN
              if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        FILL: begin
          if (mem_valid) begin
            // Bytes shift in from the top so byte 0 ends up in bits [7:0].
            fill_d = {mem_din, fill_q[DAT_W-9:8]};
            if (cnt_q == 2'd3 || clr) begin
              mem_req_d = 1'b0;
              busy_d    = 1'b0;
              state_d   = IDLE;
              if (!clr) begin
                wr_en          = 1'b1;
                valid_d[idx_q] = 1'b1;
                cache_en_d     = 1'b1;
                cache_ins_d    = wr_data;
              end
            end else begin
              cnt_d      = cnt_q + 2'd1;
              mem_addr_d = mem_addr_q + ADR_W'(1);
            end
          end else if (clr) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mem_valid) begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cache_en_q  <= 1'b0;
      cache_ins_q <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cnt_q       <= 2'd0;
      fill_q      <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      valid_q     <= '0;
`ifdef ICACHE_STAT_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cache_en_q  <= cache_en_d;
      cache_ins_q <= cache_ins_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
`ifdef ICACHE_STAT_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx_q]  <= tag_q;
      data_mem[idx_q] <= wr_data;
    end
  end

  assign cache_en  = cache_en_q;
  assign cache_ins = cache_ins_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
`ifdef ICACHE_STAT_EN
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
`endif

endmodule
